// File: rtl/spi_arb_pkg.sv
// Shared definitions for the SPI flash arbiter: grant state encoding
// and the pin levels driven while no master owns the flash.
package spi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GNT_CTRL = 2'd1,
        GNT_PROG = 2'd2,
        GUARD    = 2'd3
    } arb_state_t;

    localparam logic SPI_IDLE_CS   = 1'b1;
    localparam logic SPI_IDLE_CLK  = 1'b0;
    localparam logic SPI_IDLE_MOSI = 1'b0;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for single-bit FT2232-domain controls.
// Ports: clk, rst_n (async low), d (async in), q (synchronized out).
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spi_flash_arbiter.sv
// Grants the SPI flash pins to the read controller or the FT2232 programmer
// with a CS-high guard between owners and CPU HALT while programming.
// Ports: clk, reset (async low); ctrl req/gnt/pins; prog req/gnt/pins;
// i_SPI_MISO; o_SPI_CLK/MOSI/CS flash pins; o_halt; o_timeout_err.
// Optional read watchdog: define SPI_ARB_TIMEOUT_EN.
import spi_arb_pkg::*;

module spi_flash_arbiter #(
    parameter int GUARD_CYCLES   = 3,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic i_ctrl_req,
    output logic o_ctrl_gnt,
    input  logic i_ctrl_spi_clk,
    input  logic i_ctrl_spi_mosi,
    input  logic i_ctrl_spi_cs,
    input  logic i_prog_req,
    output logic o_prog_gnt,
    input  logic i_prog_spi_clk,
    input  logic i_prog_spi_mosi,
    input  logic i_prog_spi_cs,
    input  logic i_SPI_MISO,
    output logic o_SPI_CLK,
    output logic o_SPI_MOSI,
    output logic o_SPI_CS,
    output logic o_halt,
    output logic o_timeout_err
);

    arb_state_t state, state_nxt;
    logic [7:0] guard_cnt;
    logic       prog_req_s;
    logic       ctrl_armed;
    logic       tmo_hit;

    // MISO goes straight to both masters outside this block.
    logic unused_miso;
    assign unused_miso = i_SPI_MISO;

    sync_2ff u_prog_sync (
        .clk   (clk),
        .rst_n (reset),
        .d     (i_prog_req),
        .q     (prog_req_s)
    );

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_cnt;
    logic          tmo_err_q;

    // Fires on the last owned cycle so ownership is at most TIMEOUT_CYCLES.
    assign tmo_hit = (state == GNT_CTRL) &&
                     (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt    <= '0;
            tmo_err_q  <= 1'b0;
            ctrl_armed <= 1'b1;
        end else begin
            if (state == GNT_CTRL && !tmo_hit)
                tmo_cnt <= tmo_cnt + 1'b1;
            else
                tmo_cnt <= '0;
            tmo_err_q <= tmo_hit;
            if (tmo_hit)
                ctrl_armed <= 1'b0;
            else if (!i_ctrl_req)
                ctrl_armed <= 1'b1;
        end
    end

    assign o_timeout_err = tmo_err_q;
`else
    localparam int unused_tmo = TIMEOUT_CYCLES;

    assign tmo_hit       = 1'b0;
    assign ctrl_armed    = 1'b1;
    assign o_timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (prog_req_s)
                    state_nxt = GNT_PROG;
                else if (i_ctrl_req && ctrl_armed)
                    state_nxt = GNT_CTRL;
            end
            GNT_CTRL: begin
                if (!i_ctrl_req || tmo_hit)
                    state_nxt = GUARD;
            end
            GNT_PROG: begin
                if (!prog_req_s)
                    state_nxt = GUARD;
            end
            GUARD: begin
                if (guard_cnt == 8'd0)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            guard_cnt <= 8'd0;
        else if (state != GUARD && state_nxt == GUARD)
            guard_cnt <= 8'(GUARD_CYCLES - 1);
        else if (state == GUARD && guard_cnt != 8'd0)
            guard_cnt <= guard_cnt - 8'd1;
    end

    assign o_ctrl_gnt = (state == GNT_CTRL);
    assign o_prog_gnt = (state == GNT_PROG);
    assign o_halt     = prog_req_s | (state == GNT_PROG);

    // Owner pins pass through combinationally: no added FT SCK latency.
    always_comb begin
        o_SPI_CS   = SPI_IDLE_CS;
        o_SPI_CLK  = SPI_IDLE_CLK;
        o_SPI_MOSI = SPI_IDLE_MOSI;
        if (state == GNT_CTRL) begin
            o_SPI_CS   = i_ctrl_spi_cs;
            o_SPI_CLK  = i_ctrl_spi_clk;
            o_SPI_MOSI = i_ctrl_spi_mosi;
        end else if (state == GNT_PROG) begin
            o_SPI_CS   = i_prog_spi_cs;
            o_SPI_CLK  = i_prog_spi_clk;
            o_SPI_MOSI = i_prog_spi_mosi;
        end
    end

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Directed bench for spi_flash_arbiter with a scoreboard of expected
// output vectors {ctrl_gnt,prog_gnt,halt,cs,sck,mosi,timeout_err}.
module tb_spi_flash_arbiter;

    localparam int GUARD = 3;
    localparam int TMO   = 16;

    logic clk = 1'b0;
    logic reset;
    logic i_ctrl_req, i_ctrl_spi_clk, i_ctrl_spi_mosi, i_ctrl_spi_cs;
    logic i_prog_req, i_prog_spi_clk, i_prog_spi_mosi, i_prog_spi_cs;
    logic i_SPI_MISO;
    logic o_ctrl_gnt, o_prog_gnt, o_SPI_CLK, o_SPI_MOSI, o_SPI_CS;
    logic o_halt, o_timeout_err;

    always #5 clk = ~clk;

    spi_flash_arbiter #(
        .GUARD_CYCLES   (GUARD),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .i_ctrl_req      (i_ctrl_req),
        .o_ctrl_gnt      (o_ctrl_gnt),
        .i_ctrl_spi_clk  (i_ctrl_spi_clk),
        .i_ctrl_spi_mosi (i_ctrl_spi_mosi),
        .i_ctrl_spi_cs   (i_ctrl_spi_cs),
        .i_prog_req      (i_prog_req),
        .o_prog_gnt      (o_prog_gnt),
        .i_prog_spi_clk  (i_prog_spi_clk),
        .i_prog_spi_mosi (i_prog_spi_mosi),
        .i_prog_spi_cs   (i_prog_spi_cs),
        .i_SPI_MISO      (i_SPI_MISO),
        .o_SPI_CLK       (o_SPI_CLK),
        .o_SPI_MOSI      (o_SPI_MOSI),
        .o_SPI_CS        (o_SPI_CS),
        .o_halt          (o_halt),
        .o_timeout_err   (o_timeout_err)
    );

    typedef struct {
        string      tag;
        logic [6:0] v;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;

    function automatic logic [6:0] obs();
        return {o_ctrl_gnt, o_prog_gnt, o_halt,
                o_SPI_CS, o_SPI_CLK, o_SPI_MOSI, o_timeout_err};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_v(input string tag, input logic [6:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sbq.push_back(e);
    endtask

    task automatic check_sb();
        exp_t       e;
        logic [6:0] o;
        tests++;
        if (sbq.size() == 0) begin
            fails++;
            $error("FAIL sb_empty observed=none expected=entry");
        end else begin
            e = sbq.pop_front();
            o = obs();
            assert (o === e.v) else begin
                fails++;
                $error("FAIL %s observed=%b expected=%b", e.tag, o, e.v);
            end
        end
    endtask

    task automatic step(input string tag, input logic [6:0] v);
        expect_v(tag, v);
        tick();
        check_sb();
    endtask

    task automatic now_chk(input string tag, input logic [6:0] v);
        expect_v(tag, v);
        #1;
        check_sb();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        i_ctrl_req = 0; i_ctrl_spi_clk = 0;
        i_ctrl_spi_mosi = 0; i_ctrl_spi_cs = 1;
        i_prog_req = 0; i_prog_spi_clk = 0;
        i_prog_spi_mosi = 0; i_prog_spi_cs = 1;
        i_SPI_MISO = 0;
        repeat (2) @(negedge clk);
        now_chk("reset", 7'b0001000);
        reset = 1'b1;
        tick();

        // Read-only transaction, pins mirror the controller.
        i_ctrl_req = 1; i_ctrl_spi_cs = 0; i_ctrl_spi_mosi = 1;
        step("rd_gnt", 7'b1000010);
        for (int i = 0; i < 6; i++) begin
            i_ctrl_spi_clk  = ~i_ctrl_spi_clk;
            i_ctrl_spi_mosi = i[0];
            now_chk("rd_mirror",
                    {3'b100, 1'b0, i_ctrl_spi_clk, i_ctrl_spi_mosi, 1'b0});
            tick();
        end

        // Release: pins idle even though controller still drives them.
        i_ctrl_req = 0; i_ctrl_spi_clk = 1; i_ctrl_spi_mosi = 1;
        step("rd_rel", 7'b0001000);
        i_ctrl_req = 1;
        for (int i = 0; i < GUARD; i++)
            step("rd_guard", 7'b0001000);
        step("rd_regrant", 7'b1000110);
        i_ctrl_req = 0; i_ctrl_spi_clk = 0; i_ctrl_spi_mosi = 0;
        for (int i = 0; i <= GUARD; i++)
            step("rd_drain", 7'b0001000);

        // Both requests present at the same arbitration edge.
        i_prog_req = 1; i_prog_spi_cs = 0; i_prog_spi_clk = 1;
        step("sim_sync1", 7'b0001000);
        step("sim_halt", 7'b0011000);
        i_ctrl_req = 1; i_ctrl_spi_cs = 0;
        step("sim_pgnt", 7'b0110100);
        for (int i = 0; i < 3; i++)
            step("sim_hold", 7'b0110100);
        i_prog_req = 0;
        step("sim_drop1", 7'b0110100);
        step("sim_drop2", 7'b0110100);
        step("sim_rel", 7'b0001000);
        for (int i = 0; i < GUARD; i++)
            step("sim_guard", 7'b0001000);
        step("sim_cgnt", 7'b1000000);

        // Programmer request mid-read: no preemption.
        i_prog_req = 1;
        step("np_sync1", 7'b1000000);
        step("np_halt", 7'b1010000);
        for (int i = 0; i < 3; i++)
            step("np_hold", 7'b1010000);
        i_ctrl_req = 0; i_ctrl_spi_cs = 1;
        step("np_rel", 7'b0011000);
        for (int i = 0; i < GUARD; i++)
            step("np_guard", 7'b0011000);
        step("np_pgnt", 7'b0110100);

        // Asynchronous reset while the programmer owns the pins.
        #2;
        reset = 1'b0;
        now_chk("rst_async", 7'b0001000);
        i_prog_req = 0;
        @(negedge clk);
        reset = 1'b1;
        step("rst_after", 7'b0001000);

        // Programmer pulse that no clock edge samples.
        #1 i_prog_req = 1;
        #2 i_prog_req = 0;
        for (int i = 0; i < 4; i++)
            step("short_pulse", 7'b0001000);

`ifdef SPI_ARB_TIMEOUT_EN
        i_ctrl_req = 1; i_ctrl_spi_cs = 0;
        i_ctrl_spi_clk = 0; i_ctrl_spi_mosi = 0;
        for (int i = 1; i <= TMO; i++)
            step("tmo_own", 7'b1000000);
        step("tmo_revoke", 7'b0001001);
        for (int i = TMO + 2; i <= 40; i++)
            step("tmo_noregnt", 7'b0001000);
        i_ctrl_req = 0;
        step("tmo_low", 7'b0001000);
        i_ctrl_req = 1;
        step("tmo_regrant", 7'b1000000);
        i_ctrl_req = 0;
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
